vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 tb/tb_vga_timing_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, decoded sync/enable/strobes,
// and a pixel-tick pipeline of 1+PIPE_DELAY stages that aligns them with a downstream renderer.
module vga_timing_gen #(
  parameter int   H_ACTIVE      = 640,
  parameter int   H_FRONT_PORCH = 16,
  parameter int   H_SYNC        = 96,
  parameter int   H_BACK_PORCH  = 48,
  parameter int   V_ACTIVE      = 480,
  parameter int   V_FRONT_PORCH = 10,
  parameter int   V_SYNC        = 2,
  parameter int   V_BACK_PORCH  = 33,
  parameter logic H_SYNC_POL    = 1'b0,
  parameter logic V_SYNC_POL    = 1'b0,
  parameter int   PIPE_DELAY    = 0,
  parameter int   CNT_W         = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             h_sync,
  output logic             v_sync,
  output logic             active,
  output logic             vblank,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int HS_FIRST = H_ACTIVE + H_FRONT_PORCH;
  localparam int VS_FIRST = V_ACTIVE + V_FRONT_PORCH;

  // Only values strictly below 2^CNT_W are cast; a legal mode never needs H_TOTAL itself.
  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST_C = CNT_W'(HS_FIRST);
  localparam logic [CNT_W-1:0] HS_LAST_C  = CNT_W'(HS_FIRST + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST_C = CNT_W'(VS_FIRST);
  localparam logic [CNT_W-1:0] VS_LAST_C  = CNT_W'(VS_FIRST + V_SYNC - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic vbl;
    logic ls;
    logic fs;
  } dec_t;

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  dec_t             dec_d;
  dec_t             stage_src [PIPE_DELAY+1];
  dec_t             stage_q   [PIPE_DELAY+1];

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST_C) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    dec_d     = '0;
    dec_d.hs  = (h_cnt_q >= HS_FIRST_C) && (h_cnt_q <= HS_LAST_C);
    dec_d.vs  = (v_cnt_q >= VS_FIRST_C) && (v_cnt_q <= VS_LAST_C);
    dec_d.act = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    dec_d.vbl = (v_cnt_q >= V_ACT_C);
    dec_d.ls  = (h_cnt_q == '0);
    dec_d.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_comb begin
    stage_src[0] = dec_d;
    for (int i = 1; i <= PIPE_DELAY; i++) begin
      stage_src[i] = stage_q[i-1];
    end
  end

  // The last stage drops its strobes on any non-tick clock so they are exactly one clk wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= PIPE_DELAY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= PIPE_DELAY; i++) begin
        if (pix_en) begin
          stage_q[i] <= stage_src[i];
        end else if (i == PIPE_DELAY) begin
          stage_q[i].ls <= 1'b0;
          stage_q[i].fs <= 1'b0;
        end
      end
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign h_sync      = stage_q[PIPE_DELAY].hs ? H_SYNC_POL : ~H_SYNC_POL;
  assign v_sync      = stage_q[PIPE_DELAY].vs ? V_SYNC_POL : ~V_SYNC_POL;
  assign active      = stage_q[PIPE_DELAY].act;
  assign vblank      = stage_q[PIPE_DELAY].vbl;
  assign line_start  = stage_q[PIPE_DELAY].ls;
  assign frame_start = stage_q[PIPE_DELAY].fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-mode instances (plain, PIPE_DELAY=3, positive sync)
// and one default 640x480 instance, checked every clock against a raster model.
module tb_vga_timing_gen;

  localparam int NI = 4;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] x0, y0, x1, y1, x2, y2;
  logic [9:0] x3, y3;
  logic hs0, vs0, act0, vbl0, ls0, fs0;
  logic hs1, vs1, act1, vbl1, ls1, fs1;
  logic hs2, vs2, act2, vbl2, ls2, fs2;
  logic hs3, vs3, act3, vbl3, ls3, fs3;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(2),
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_DELAY(0), .CNT_W(4)
  ) u_small (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x0), .y(y0),
    .h_sync(hs0), .v_sync(vs0), .active(act0), .vblank(vbl0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(2),
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_DELAY(3), .CNT_W(4)
  ) u_small_d3 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x1), .y(y1),
    .h_sync(hs1), .v_sync(vs1), .active(act1), .vblank(vbl1),
    .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(2),
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIPE_DELAY(0), .CNT_W(4)
  ) u_small_pos (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x2), .y(y2),
    .h_sync(hs2), .v_sync(vs2), .active(act2), .vblank(vbl2),
    .line_start(ls2), .frame_start(fs2)
  );

  vga_timing_gen u_vga (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x3), .y(y3),
    .h_sync(hs3), .v_sync(vs3), .active(act3), .vblank(vbl3),
    .line_start(ls3), .frame_start(fs3)
  );

  int   m_ha [NI] = '{8, 8, 8, 640};
  int   m_hf [NI] = '{2, 2, 2, 16};
  int   m_hs [NI] = '{3, 3, 3, 96};
  int   m_hb [NI] = '{2, 2, 2, 48};
  int   m_va [NI] = '{4, 4, 4, 480};
  int   m_vf [NI] = '{1, 1, 1, 10};
  int   m_vs [NI] = '{2, 2, 2, 2};
  int   m_vb [NI] = '{1, 1, 1, 33};
  int   m_dly[NI] = '{0, 3, 0, 0};
  logic m_hpol[NI] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic m_vpol[NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

  int         m_h [NI];
  int         m_v [NI];
  logic [5:0] m_out [NI];

  // Per-instance expected decode queues; depth equals the extra pipeline stages.
  logic [5:0] exp_q0[$];
  logic [5:0] exp_q1[$];
  logic [5:0] exp_q2[$];
  logic [5:0] exp_q3[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [5:0] model_dec(input int i);
    int   hs_first = m_ha[i] + m_hf[i];
    int   vs_first = m_va[i] + m_vf[i];
    logic hs, vs, act, vbl, ls, fs;
    hs  = (m_h[i] >= hs_first) && (m_h[i] <= hs_first + m_hs[i] - 1);
    vs  = (m_v[i] >= vs_first) && (m_v[i] <= vs_first + m_vs[i] - 1);
    act = (m_h[i] < m_ha[i]) && (m_v[i] < m_va[i]);
    vbl = (m_v[i] >= m_va[i]);
    ls  = (m_h[i] == 0);
    fs  = (m_h[i] == 0) && (m_v[i] == 0);
    return {hs, vs, act, vbl, ls, fs};
  endfunction

  function automatic void q_clear(input int i);
    case (i)
      0:       exp_q0.delete();
      1:       exp_q1.delete();
      2:       exp_q2.delete();
      default: exp_q3.delete();
    endcase
  endfunction

  function automatic void q_push(input int i, input logic [5:0] d);
    case (i)
      0:       exp_q0.push_back(d);
      1:       exp_q1.push_back(d);
      2:       exp_q2.push_back(d);
      default: exp_q3.push_back(d);
    endcase
  endfunction

  function automatic logic [5:0] q_pop(input int i);
    logic [5:0] d = '0;
    case (i)
      0:       if (exp_q0.size() > 0) d = exp_q0.pop_front();
      1:       if (exp_q1.size() > 0) d = exp_q1.pop_front();
      2:       if (exp_q2.size() > 0) d = exp_q2.pop_front();
      default: if (exp_q3.size() > 0) d = exp_q3.pop_front();
    endcase
    return d;
  endfunction

  task automatic model_edge(input logic rst, input logic en);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_h[i]   = 0;
        m_v[i]   = 0;
        m_out[i] = '0;
        q_clear(i);
        for (int k = 0; k < m_dly[i]; k++) q_push(i, 6'b0);
      end else if (en) begin
        q_push(i, model_dec(i));
        m_out[i] = q_pop(i);
        if (m_h[i] == m_ha[i] + m_hf[i] + m_hs[i] + m_hb[i] - 1) begin
          m_h[i] = 0;
          m_v[i] = (m_v[i] == m_va[i] + m_vf[i] + m_vs[i] + m_vb[i] - 1) ? 0 : m_v[i] + 1;
        end else begin
          m_h[i] = m_h[i] + 1;
        end
      end else begin
        m_out[i] = m_out[i] & 6'b111100;
      end
    end
  endtask

  function automatic logic [31:0] exp_vec(input int i);
    logic hs_lvl = m_out[i][5] ? m_hpol[i] : ~m_hpol[i];
    logic vs_lvl = m_out[i][4] ? m_vpol[i] : ~m_vpol[i];
    return {6'b0, 10'(m_h[i]), 10'(m_v[i]), hs_lvl, vs_lvl, m_out[i][3:0]};
  endfunction

  function automatic logic [31:0] obs_vec(input int i);
    case (i)
      0:       return {6'b0, 6'b0, x0, 6'b0, y0, hs0, vs0, act0, vbl0, ls0, fs0};
      1:       return {6'b0, 6'b0, x1, 6'b0, y1, hs1, vs1, act1, vbl1, ls1, fs1};
      2:       return {6'b0, 6'b0, x2, 6'b0, y2, hs2, vs2, act2, vbl2, ls2, fs2};
      default: return {6'b0, x3, y3, hs3, vs3, act3, vbl3, ls3, fs3};
    endcase
  endfunction

  int   cyc = 0;
  int   last_fs0 = -1, fs_per0 = 0, ls_cnt0 = 0, lpf0 = 0;
  int   last_ls3 = -1, ls_per3 = 0, act_cnt3 = 0, act_line3 = 0;
  int   hs_fall3 = 0, hs_off3 = 0, hs_len3 = 0;
  logic prev_hs3 = 1'b1;

  task automatic measure();
    cyc++;
    if (fs0) begin
      if (last_fs0 >= 0) fs_per0 = cyc - last_fs0;
      last_fs0 = cyc;
      lpf0     = ls_cnt0;
      ls_cnt0  = 0;
    end
    if (ls0) ls_cnt0++;
    if (ls3) begin
      if (last_ls3 >= 0) begin
        ls_per3   = cyc - last_ls3;
        act_line3 = act_cnt3;
      end
      act_cnt3 = 0;
      last_ls3 = cyc;
    end
    if (act3) act_cnt3++;
    if (!hs3 && prev_hs3) begin
      hs_fall3 = cyc;
      hs_off3  = cyc - last_ls3;
    end
    if (hs3 && !prev_hs3) hs_len3 = cyc - hs_fall3;
    prev_hs3 = hs3;
  endtask

  task automatic clk_step(input logic rst, input logic en);
    @(negedge clk);
    reset  = rst;
    pix_en = en;
    @(posedge clk);
    #1;
    model_edge(rst, en);
    check_val("inst0", obs_vec(0), exp_vec(0));
    check_val("inst1_d3", obs_vec(1), exp_vec(1));
    check_val("inst2_pos", obs_vec(2), exp_vec(2));
    check_val("inst3_vga", obs_vec(3), exp_vec(3));
    measure();
  endtask

  task automatic release_latency(input string tag);
    int fs_lat0 = -1, fs_lat1 = -1, act_lat1 = -1;
    for (int k = 1; k <= 10; k++) begin
      clk_step(1'b0, 1'b1);
      if (fs0 && fs_lat0 < 0) fs_lat0 = k;
      if (fs1 && fs_lat1 < 0) fs_lat1 = k;
      if (act1 && act_lat1 < 0) act_lat1 = k;
    end
    check_val({tag, "_fs_lat_d0"}, fs_lat0, 1);
    check_val({tag, "_fs_lat_d3"}, fs_lat1, 4);
    check_val({tag, "_act_lat_d3"}, act_lat1, 4);
  endtask

  initial begin
    int found;
    repeat (3) clk_step(1'b1, 1'b1);
    release_latency("por");

    repeat (1690) clk_step(1'b0, 1'b1);
    check_val("fs_period_en1", fs_per0, 120);
    check_val("lines_per_frame", lpf0, 8);
    check_val("vga_line_period", ls_per3, 800);
    check_val("vga_active_per_line", act_line3, 640);
    check_val("vga_hsync_offset", hs_off3, 656);
    check_val("vga_hsync_width", hs_len3, 96);

    repeat (400) begin
      clk_step(1'b0, 1'b1);
      clk_step(1'b0, 1'b0);
    end
    check_val("fs_period_en2", fs_per0, 240);

    repeat (400) clk_step(1'b0, 1'($urandom_range(0, 1)));

    found = 0;
    for (int k = 0; k < 200; k++) begin
      clk_step(1'b0, 1'b1);
      if (x0 == 4'd5 && y0 == 4'd3) begin
        found = 1;
        break;
      end
    end
    check_val("reach_mid_frame", found, 1);
    repeat (5) clk_step(1'b1, 1'($urandom_range(0, 1)));
    release_latency("midrst");

    repeat (300) clk_step(1'b0, 1'($urandom_range(0, 3) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
